// File: rtl/burst_wf_pkg.sv
// Shared definitions for the burst read/write masters: FSM states and burst/FIFO sizing.
package burst_wf_pkg;

  localparam int unsigned BURST_COUNT       = 8;
  localparam int unsigned BYTE_ENABLE_WIDTH = 4;
  localparam int unsigned BURST_BYTES       = BURST_COUNT * BYTE_ENABLE_WIDTH;
  localparam int unsigned FIFO_DEPTH        = 32;
  localparam int unsigned FIFO_AW           = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_REQ   = 2'd2,
    ST_DRAIN = 2'd3
  } wf_state_e;

endpackage

// File: rtl/burst_read_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered output stage.
// free reports unused storage entries; the output register is extra slack.
module burst_read_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned AW         = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [AW:0]           free
);

  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  out_valid;
  logic                  pop_c;

  // Refill the output register whenever it is empty or being consumed.
  assign pop_c = (count != '0) && (!out_valid || rd_en);
  assign empty = ~out_valid;
  assign full  = (count == CW'(DEPTH));
  assign free  = CW'(DEPTH) - count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c) begin
        rd_ptr    <= rd_ptr + AW'(1);
        rd_data   <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (rd_en) begin
        out_valid <= 1'b0;
      end
      count <= count + CW'(wr_en) - CW'(pop_c);
    end
  end

endmodule

// File: rtl/burst_read_wf.sv
// Credit-based Avalon-MM burst read master feeding a valid/ready stream via a FWFT FIFO.
// Define BURST_READ_WF_LOOP_EN to restart directly from DRAIN when ctrl_start is held.
import burst_wf_pkg::*;

module burst_read_wf #(
  parameter int unsigned ADDRESS_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned BYTE_ENABLE_WIDTH = burst_wf_pkg::BYTE_ENABLE_WIDTH,
  parameter int unsigned BURST_COUNT       = burst_wf_pkg::BURST_COUNT,
  parameter int unsigned BURST_WIDTH       = 4,
  parameter int unsigned LENGTH_WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH        = burst_wf_pkg::FIFO_DEPTH,
  parameter int unsigned FIFO_AW           = burst_wf_pkg::FIFO_AW
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [ADDRESS_WIDTH-1:0]     master_address,
  output logic                         master_read,
  output logic [BURST_WIDTH-1:0]       master_burstcount,
  output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
  input  logic                         master_waitrequest,
  input  logic [DATA_WIDTH-1:0]        master_readdata,
  input  logic                         master_readdatavalid,
  input  logic                         ctrl_start,
  input  logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress,
  input  logic [LENGTH_WIDTH-1:0]      ctrl_numbursts,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  output logic [DATA_WIDTH-1:0]        st_data,
  output logic                         st_valid,
  input  logic                         st_ready
);

  localparam int unsigned STEP_BYTES = BURST_COUNT * BYTE_ENABLE_WIDTH;
  localparam int unsigned PW         = FIFO_AW + 1;
  localparam int unsigned CW         = FIFO_AW + 2;

  wf_state_e                 state;
  wf_state_e                 state_next;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [LENGTH_WIDTH-1:0]   bursts_left;
  logic [FIFO_AW:0]          pending;
  logic [FIFO_AW:0]          fifo_free;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_wr;

  logic room_c;
  logic start_ok_c;
  logic loop_c;
  logic issue_c;
  logic accept_c;
  logic latch_c;
  logic done_c;
  logic finish_c;

  assign master_byteenable = '1;
  assign st_valid          = ~fifo_empty;

  // Data with nothing outstanding is stale (e.g. left over from a reset) and is dropped.
  assign fifo_wr    = master_readdatavalid && (pending != '0);
  assign room_c     = CW'(fifo_free) >= (CW'(pending) + CW'(BURST_COUNT));
  assign start_ok_c = ctrl_start && (ctrl_numbursts != '0);

`ifdef BURST_READ_WF_LOOP_EN
  assign loop_c = start_ok_c;
`else
  assign loop_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_ok_c) state_next = ST_ARB;
      ST_ARB: begin
        if (bursts_left == '0) state_next = ST_DRAIN;
        else if (room_c)       state_next = ST_REQ;
      end
      ST_REQ:   if (!master_waitrequest) state_next = ST_ARB;
      ST_DRAIN: if (pending == '0) state_next = loop_c ? ST_ARB : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_c  = 1'b0;
    accept_c = 1'b0;
    latch_c  = 1'b0;
    done_c   = 1'b0;
    finish_c = 1'b0;
    case (state)
      ST_IDLE: begin
        latch_c = start_ok_c;
        done_c  = ctrl_start && (ctrl_numbursts == '0);
      end
      ST_ARB:   issue_c  = (bursts_left != '0) && room_c;
      ST_REQ:   accept_c = !master_waitrequest;
      ST_DRAIN: begin
        if (pending == '0) begin
          done_c   = 1'b1;
          latch_c  = loop_c;
          finish_c = !loop_c;
        end
      end
      default: ;
    endcase
  end

  // Request, progress and credit registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      master_address    <= '0;
      master_read       <= 1'b0;
      master_burstcount <= '0;
      ctrl_busy         <= 1'b0;
      ctrl_done         <= 1'b0;
      addr_q            <= '0;
      bursts_left       <= '0;
      pending           <= '0;
    end else begin
      ctrl_done <= done_c;
      if (latch_c) begin
        addr_q      <= ctrl_baseaddress;
        bursts_left <= ctrl_numbursts;
        ctrl_busy   <= 1'b1;
      end else if (finish_c) begin
        ctrl_busy <= 1'b0;
      end
      if (issue_c) begin
        master_read       <= 1'b1;
        master_address    <= addr_q;
        master_burstcount <= BURST_WIDTH'(BURST_COUNT);
      end
      if (accept_c) begin
        master_read <= 1'b0;
        addr_q      <= addr_q + ADDRESS_WIDTH'(STEP_BYTES);
        bursts_left <= bursts_left - LENGTH_WIDTH'(1);
      end
      pending <= pending + (accept_c ? PW'(BURST_COUNT) : PW'(0)) - PW'(fifo_wr);
    end
  end

  burst_read_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .AW         (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (master_readdata),
    .rd_en   (st_ready),
    .rd_data (st_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .free    (fifo_free)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_wr && fifo_full && !(st_valid && st_ready)));

endmodule

// File: tb/tb_burst_read_wf.sv
// Directed bench for burst_read_wf: behavioural Avalon slave, stream sink, hand-computed expectations.
module tb_burst_read_wf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] master_address;
  logic        master_read;
  logic [3:0]  master_burstcount;
  logic [3:0]  master_byteenable;
  logic        master_waitrequest;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        ctrl_start;
  logic [31:0] ctrl_baseaddress;
  logic [15:0] ctrl_numbursts;
  logic        ctrl_busy;
  logic        ctrl_done;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;

  always #5 clk = ~clk;

  burst_read_wf dut (
    .clk                  (clk),
    .reset                (reset),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_burstcount    (master_burstcount),
    .master_byteenable    (master_byteenable),
    .master_waitrequest   (master_waitrequest),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .ctrl_start           (ctrl_start),
    .ctrl_baseaddress     (ctrl_baseaddress),
    .ctrl_numbursts       (ctrl_numbursts),
    .ctrl_busy            (ctrl_busy),
    .ctrl_done            (ctrl_done),
    .st_data              (st_data),
    .st_valid             (st_valid),
    .st_ready             (st_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Slave and sink bookkeeping
  int          stall_left = 0, stall_seen = 0, stall_bad = 0;
  int          req_count = 0, words_owed = 0, ret_budget = 1000000, ret_count = 0;
  int          done_count = 0;
  logic [31:0] next_data = 32'd1;
  logic [31:0] stall_addr = '0;
  logic [3:0]  stall_bc = '0;
  logic [31:0] req_addr [$];
  logic [31:0] req_bc   [$];
  logic [31:0] rx       [$];

  // Avalon slave: decides at the falling edge what the DUT samples at the next rising edge.
  initial begin : slave
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    forever begin
      @(negedge clk);
      master_readdatavalid = 1'b0;
      if (words_owed > 0 && ret_budget > 0) begin
        master_readdatavalid = 1'b1;
        master_readdata      = next_data;
        next_data++;
        words_owed--;
        ret_budget--;
        ret_count++;
      end
      if (master_read && stall_left > 0) begin
        if (!master_waitrequest) begin
          stall_addr = master_address;
          stall_bc   = master_burstcount;
        end else if (master_address != stall_addr || master_burstcount != stall_bc) begin
          stall_bad++;
        end
        master_waitrequest = 1'b1;
        stall_left--;
        stall_seen++;
      end else begin
        master_waitrequest = 1'b0;
      end
      if (master_read && !master_waitrequest) begin
        req_count++;
        req_addr.push_back(master_address);
        req_bc.push_back(32'(master_burstcount));
        words_owed += int'(master_burstcount);
      end
    end
  end

  initial begin : sink
    forever begin
      @(negedge clk);
      if (st_valid && st_ready) rx.push_back(st_data);
      if (ctrl_done) done_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    req_count  = 0;
    done_count = 0;
    next_data  = 32'd1;
    req_addr.delete();
    req_bc.delete();
    rx.delete();
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [15:0] nb);
    ctrl_baseaddress = base;
    ctrl_numbursts   = nb;
    ctrl_start       = 1'b1;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    logic was_busy;
    was_busy = ctrl_busy;
    for (int k = 0; k < max; k++) begin
      if (ctrl_done) break;
      was_busy = ctrl_busy;
      tick();
    end
    check({tag, "_done"}, 32'(ctrl_done), 32'd1);
    check({tag, "_busy_fall"}, 32'(ctrl_busy), 32'd0);
    check({tag, "_busy_before"}, 32'(was_busy), 32'd1);
    tick();
    check({tag, "_done_1cyc"}, 32'(ctrl_done), 32'd0);
  endtask

  task automatic wait_rx(input string tag, input int n, input int max);
    for (int k = 0; k < max; k++) begin
      if (rx.size() >= n) break;
      tick();
    end
    check({tag, "_rx_count"}, 32'(rx.size()), 32'(n));
  endtask

  initial begin : main
    reset            = 1'b1;
    ctrl_start       = 1'b0;
    ctrl_baseaddress = '0;
    ctrl_numbursts   = '0;
    st_ready         = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_read",  32'(master_read),       32'd0);
    check("rst_addr",  master_address,         32'd0);
    check("rst_bc",    32'(master_burstcount), 32'd0);
    check("rst_be",    32'(master_byteenable), 32'h0000000F);
    check("rst_busy",  32'(ctrl_busy),         32'd0);
    check("rst_done",  32'(ctrl_done),         32'd0);
    check("rst_valid", 32'(st_valid),          32'd0);
    check("rst_data",  st_data,                32'd0);
    reset = 1'b0;
    tick();

    // Single burst with start-to-read timing
    clear_log();
    ctrl_baseaddress = 32'h3800_0000;
    ctrl_numbursts   = 16'd1;
    ctrl_start       = 1'b1;
    tick();
    ctrl_start = 1'b0;
    check("t1_busy_n",  32'(ctrl_busy),   32'd1);
    check("t1_read_n",  32'(master_read), 32'd0);
    tick();
    check("t1_read_n1", 32'(master_read), 32'd1);
    check("t1_addr_n1", master_address,   32'h3800_0000);
    check("t1_bc_n1",   32'(master_burstcount), 32'd8);
    wait_done("t1", 100);
    wait_rx("t1", 8, 100);
    check("t1_reqs",  32'(req_count), 32'd1);
    check("t1_addr",  req_addr[0],    32'h3800_0000);
    check("t1_bc",    req_bc[0],      32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t1_rx%0d", i), rx[i], 32'(i + 1));
    check("t1_done_cnt", 32'(done_count), 32'd1);

    // Credit stall with consumer blocked, then release
    clear_log();
    st_ready = 1'b0;
    start_xfer(32'h0000_1000, 16'd8);
    repeat (80) tick();
    check("t2_reqs_stall", 32'(req_count), 32'd4);
    check("t2_a0", req_addr[0], 32'h0000_1000);
    check("t2_a1", req_addr[1], 32'h0000_1020);
    check("t2_a2", req_addr[2], 32'h0000_1040);
    check("t2_a3", req_addr[3], 32'h0000_1060);
    check("t2_busy",  32'(ctrl_busy), 32'd1);
    check("t2_valid", 32'(st_valid),  32'd1);
    check("t2_hold",  st_data,        32'd1);
    st_ready = 1'b1;
    wait_done("t2", 400);
    wait_rx("t2", 64, 200);
    check("t2_reqs", 32'(req_count), 32'd8);
    check("t2_a7",   req_addr[7],    32'h0000_10E0);
    for (int i = 0; i < 64; i++) check($sformatf("t2_rx%0d", i), rx[i], 32'(i + 1));

    // Waitrequest stall
    clear_log();
    stall_left = 5;
    stall_seen = 0;
    stall_bad  = 0;
    start_xfer(32'h0000_0200, 16'd1);
    wait_done("t3", 100);
    wait_rx("t3", 8, 100);
    check("t3_stall_cycles", 32'(stall_seen), 32'd5);
    check("t3_stable",       32'(stall_bad),  32'd0);
    check("t3_reqs",         32'(req_count),  32'd1);
    check("t3_addr",         req_addr[0],     32'h0000_0200);
    check("t3_last",         rx[7],           32'd8);

    // Zero-length request
    clear_log();
    ctrl_numbursts = 16'd0;
    ctrl_start     = 1'b1;
    tick();
    ctrl_start = 1'b0;
    check("t4_done", 32'(ctrl_done),   32'd1);
    check("t4_busy", 32'(ctrl_busy),   32'd0);
    check("t4_read", 32'(master_read), 32'd0);
    tick();
    check("t4_done_1cyc", 32'(ctrl_done), 32'd0);
    repeat (5) tick();
    check("t4_reqs",  32'(req_count), 32'd0);
    check("t4_busy2", 32'(ctrl_busy), 32'd0);

    // Reset in the middle of a burst; the remaining words must be dropped
    clear_log();
    ret_budget = 3;
    ret_count  = 0;
    start_xfer(32'h0000_0300, 16'd1);
    for (int k = 0; k < 50; k++) begin
      if (ret_count >= 3) break;
      tick();
    end
    tick();
    tick();
    check("t5_rx_pre", 32'(rx.size()), 32'd3);
    reset = 1'b1;
    #1;
    check("t5_read",  32'(master_read),       32'd0);
    check("t5_addr",  master_address,         32'd0);
    check("t5_bc",    32'(master_burstcount), 32'd0);
    check("t5_busy",  32'(ctrl_busy),         32'd0);
    check("t5_valid", 32'(st_valid),          32'd0);
    tick();
    reset      = 1'b0;
    ret_budget = 1000000;
    repeat (12) tick();
    check("t5_rx_stale",    32'(rx.size()), 32'd3);
    check("t5_valid_stale", 32'(st_valid),  32'd0);
    clear_log();
    next_data = 32'd100;
    start_xfer(32'h0000_0400, 16'd1);
    wait_done("t5", 100);
    wait_rx("t5", 8, 100);
    check("t5_new_addr", req_addr[0], 32'h0000_0400);
    check("t5_new_rx0",  rx[0],       32'd100);
    check("t5_new_rx7",  rx[7],       32'd107);

    // Address wrap
    clear_log();
    start_xfer(32'hFFFF_FFE0, 16'd2);
    wait_done("t6", 200);
    wait_rx("t6", 16, 100);
    check("t6_reqs", 32'(req_count), 32'd2);
    check("t6_a0",   req_addr[0],    32'hFFFF_FFE0);
    check("t6_a1",   req_addr[1],    32'h0000_0000);
    check("t6_last", rx[15],         32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
